// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I stage controller.
// Contents: 3-bit stage encoding, the nine legal opcodes plus SYSTEM, and a legality helper.
// Imported by stage_controller and by anything that needs to decode the stage.
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // True for opcodes that proceed to EXEC; SYSTEM is deliberately excluded
   // because it stops the core without being flagged illegal.
   function automatic logic opc_is_legal(input logic [6:0] opc);
      logic ok;
      ok = 1'b0;
      case (opc)
         OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
         OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: ok = 1'b1;
         default:                               ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/stage_controller.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, HALT on SYSTEM/illegal.
// Latency: 4 cycles for ALU/JAL ops, 3 for branches, 4 for stores and 5 for loads, plus memory waits.
// Backpressure: memReady low holds FETCH and MEM; other stages never stall. HALT exits only on rst.
// Ports: clk/rst (sync, active-high); instr+memReady from memory; memRead/memWrite requests;
//        irLoad IR capture; pcEnable/jalEnable/branch PC control; regWrite RF strobe;
//        halted/illegal status; instret retired-instruction counter.
module stage_controller
   import rv_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = FETCH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        memReady,
   output logic        memRead,
   output logic        memWrite,
   output logic        irLoad,
   output logic        pcEnable,
   output logic        jalEnable,
   output logic        branch,
   output logic        regWrite,
   output logic        halted,
   output logic        illegal,
   output logic [31:0] instret
);

   state_t      state;
   state_t      state_nxt;
   logic [6:0]  opc;
   logic        illegal_q;
   logic [31:0] instret_q;
   logic [31:0] instret_nxt;

   // Ungated decode; the ports below force everything to zero while rst is high.
   logic mem_read_c;
   logic mem_write_c;
   logic ir_load_c;
   logic pc_enable_c;
   logic jal_enable_c;
   logic branch_c;
   logic reg_write_c;
   logic halted_c;

   // Only the opcode field of the word is used by the controller.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr[31:7];

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RESET_STATE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:  if (memReady) state_nxt = DECODE;
         DECODE: begin
            if (opc_is_legal(opc)) state_nxt = EXEC;
            else                   state_nxt = HALT;
         end
         EXEC: begin
            if (opc == OPC_BRANCH)                         state_nxt = FETCH;
            else if (opc == OPC_LOAD || opc == OPC_STORE)  state_nxt = MEM;
            else                                           state_nxt = WB;
         end
         MEM: begin
            if (memReady) state_nxt = (opc == OPC_LOAD) ? WB : FETCH;
         end
         WB:      state_nxt = FETCH;
         HALT:    state_nxt = HALT;
         default: state_nxt = RESET_STATE;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      ir_load_c    = 1'b0;
      pc_enable_c  = 1'b0;
      jal_enable_c = 1'b0;
      branch_c     = 1'b0;
      reg_write_c  = 1'b0;
      halted_c     = 1'b0;
      case (state)
         FETCH: begin
            mem_read_c = 1'b1;
            ir_load_c  = memReady;
         end
         EXEC: begin
            if (opc == OPC_BRANCH) begin
               branch_c    = 1'b1;
               pc_enable_c = 1'b1;
            end
         end
         MEM: begin
            mem_read_c  = (opc == OPC_LOAD);
            mem_write_c = (opc == OPC_STORE);
            // A store has no WB stage, so it retires on the cycle its write is
            // acknowledged; this keeps pcEnable to exactly one cycle per store.
            pc_enable_c = (opc == OPC_STORE) && memReady;
         end
         WB: begin
            reg_write_c  = 1'b1;
            pc_enable_c  = 1'b1;
            jal_enable_c = (opc == OPC_JAL) || (opc == OPC_JALR);
         end
         HALT:    halted_c = 1'b1;
         default: ;
      endcase
   end

   // ---------------- opcode latch ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         opc <= 7'd0;
      end else if (state == FETCH && memReady) begin
         opc <= instr[6:0];
      end
   end

   // ---------------- illegal flag ----------------
   // Set on the DECODE -> HALT transition for anything that is not SYSTEM,
   // then held for the whole HALT period.
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else if (state == DECODE && !opc_is_legal(opc) && opc != OPC_SYSTEM) begin
         illegal_q <= 1'b1;
      end
   end

   // ---------------- retired-instruction counter ----------------
   // Wraps naturally at 2^32.
   assign instret_nxt = pc_enable_c ? (instret_q + 32'd1) : instret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= 32'd0;
      end else begin
         instret_q <= instret_nxt;
      end
   end

   // ---------------- port drive ----------------
   // Reset blanks every output regardless of the pre-reset state or memReady.
   assign memRead   = !rst && mem_read_c;
   assign memWrite  = !rst && mem_write_c;
   assign irLoad    = !rst && ir_load_c;
   assign pcEnable  = !rst && pc_enable_c;
   assign jalEnable = !rst && jal_enable_c;
   assign branch    = !rst && branch_c;
   assign regWrite  = !rst && reg_write_c;
   assign halted    = !rst && halted_c;
   assign illegal   = !rst && illegal_q;
   assign instret   = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_stage_controller.sv
// Testbench for stage_controller: per-cycle directed vectors plus a counter-wrap sequence.
// Each vector drives rst/memReady/instr after a rising edge and checks all outputs at the falling edge.
// Summary line reports total comparisons and failures.
module tb_stage_controller;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        memReady;
   logic        memRead;
   logic        memWrite;
   logic        irLoad;
   logic        pcEnable;
   logic        jalEnable;
   logic        branch;
   logic        regWrite;
   logic        halted;
   logic        illegal;
   logic [31:0] instret;

   int checks   = 0;
   int failures = 0;

   stage_controller dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .memReady  (memReady),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .irLoad    (irLoad),
      .pcEnable  (pcEnable),
      .jalEnable (jalEnable),
      .branch    (branch),
      .regWrite  (regWrite),
      .halted    (halted),
      .illegal   (illegal),
      .instret   (instret)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Flag order: memRead memWrite irLoad pcEnable jalEnable branch regWrite halted illegal
   localparam logic [8:0] NONE = 9'h000;
   localparam logic [8:0] RD   = 9'h100;
   localparam logic [8:0] WR   = 9'h080;
   localparam logic [8:0] IR   = 9'h040;
   localparam logic [8:0] PC   = 9'h020;
   localparam logic [8:0] JL   = 9'h010;
   localparam logic [8:0] BR   = 9'h008;
   localparam logic [8:0] RW   = 9'h004;
   localparam logic [8:0] HT   = 9'h002;
   localparam logic [8:0] IL   = 9'h001;

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW    = 32'h00002103;
   localparam logic [31:0] I_BEQ   = 32'h00000463;
   localparam logic [31:0] I_JAL   = 32'h008000EF;
   localparam logic [31:0] I_SW    = 32'h00202023;
   localparam logic [31:0] I_BAD   = 32'h0000007F;
   localparam logic [31:0] I_ECALL = 32'h00000073;

   typedef struct {
      logic        rst;
      logic        mr;
      logic [31:0] instr;
      logic [8:0]  flags;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic m, input logic [31:0] i,
                      input logic [8:0] f, input logic [31:0] c);
      vec_t v;
      v.rst   = r;
      v.mr    = m;
      v.instr = i;
      v.flags = f;
      v.cnt   = c;
      vecs.push_back(v);
   endtask

   function automatic logic [8:0] flags_now();
      return {memRead, memWrite, irLoad, pcEnable, jalEnable, branch, regWrite, halted, illegal};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pc_count;
      rst      = 1'b1;
      memReady = 1'b0;
      instr    = 32'd0;

      // Reset held with memReady high: reset must win.
      add(1, 1, 0, NONE, 0);
      add(1, 1, 0, NONE, 0);
      // OP-IMM, memory ready at once: irLoad cycle 1, WB cycle 4.
      add(0, 1, I_ADDI, RD | IR, 0);
      add(0, 0, I_ADDI, NONE,    0);
      add(0, 0, I_ADDI, NONE,    0);
      add(0, 0, I_ADDI, RW | PC, 0);
      // LOAD: 3 FETCH cycles (2 waiting), DECODE, EXEC, 3 MEM cycles (2 waiting), WB = 9.
      add(0, 0, I_LW, RD,      1);
      add(0, 0, I_LW, RD,      1);
      add(0, 1, I_LW, RD | IR, 1);
      add(0, 0, I_LW, NONE,    1);
      add(0, 0, I_LW, NONE,    1);
      add(0, 0, I_LW, RD,      1);
      add(0, 0, I_LW, RD,      1);
      add(0, 1, I_LW, RD,      1);
      add(0, 0, I_LW, RW | PC, 1);
      // BEQ: branch and pcEnable in EXEC only, straight back to FETCH.
      add(0, 1, I_BEQ, RD | IR, 2);
      add(0, 0, I_BEQ, NONE,    2);
      add(0, 0, I_BEQ, BR | PC, 2);
      // JAL: jalEnable, pcEnable, regWrite together in WB.
      add(0, 1, I_JAL, RD | IR,      3);
      add(0, 0, I_JAL, NONE,         3);
      add(0, 0, I_JAL, NONE,         3);
      add(0, 0, I_JAL, RW | PC | JL, 3);
      // STORE: memReady outside FETCH/MEM is ignored; retires on the write ack.
      add(0, 1, I_SW, RD | IR, 4);
      add(0, 1, I_SW, NONE,    4);
      add(0, 1, I_SW, NONE,    4);
      add(0, 0, I_SW, WR,      4);
      add(0, 1, I_SW, WR | PC, 4);
      // LOAD interrupted by reset while waiting in MEM.
      add(0, 1, I_LW, RD | IR, 5);
      add(0, 0, I_LW, NONE,    5);
      add(0, 0, I_LW, NONE,    5);
      add(0, 0, I_LW, RD,      5);
      add(1, 1, I_LW, NONE,    0);
      add(0, 0, I_LW, RD,      0);
      // One OP-IMM so instret is non-zero going into HALT.
      add(0, 1, I_ADDI, RD | IR, 0);
      add(0, 0, I_ADDI, NONE,    0);
      add(0, 0, I_ADDI, NONE,    0);
      add(0, 0, I_ADDI, RW | PC, 0);
      // Illegal opcode 0x7F: HALT with illegal, then 10 idle cycles.
      add(0, 1, I_BAD, RD | IR, 1);
      add(0, 0, I_BAD, NONE,    1);
      add(0, 0, I_BAD, HT | IL, 1);
      for (int k = 0; k < 10; k++) add(0, k[0], I_BAD, HT | IL, 1);
      // Reset leaves HALT; SYSTEM halts without illegal.
      add(1, 0, 0, NONE, 0);
      add(0, 1, I_ECALL, RD | IR, 0);
      add(0, 0, I_ECALL, NONE,    0);
      add(0, 0, I_ECALL, HT,      0);
      add(0, 1, I_ECALL, HT,      0);
      add(1, 0, 0, NONE, 0);
      add(0, 0, 0, RD,   0);

      foreach (vecs[i]) begin
         rst      = vecs[i].rst;
         memReady = vecs[i].mr;
         instr    = vecs[i].instr;
         @(negedge clk);
         chk($sformatf("vec%0d_flags", i), {23'd0, flags_now()}, {23'd0, vecs[i].flags});
         chk($sformatf("vec%0d_instret", i), instret, vecs[i].cnt);
         if (memRead && memWrite) chk($sformatf("vec%0d_rdwr_excl", i), 32'd1, 32'd0);
         @(posedge clk);
         #1;
      end

      // Counter wrap: preset instret to all-ones while idle in FETCH, then retire one OP-IMM.
      memReady = 1'b0;
      force dut.instret_nxt = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.instret_nxt;
      @(negedge clk);
      chk("wrap_preset", instret, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      pc_count = 0;
      for (int c = 0; c < 4; c++) begin
         memReady = (c == 0);
         instr    = I_ADDI;
         @(negedge clk);
         if (pcEnable) pc_count++;
         @(posedge clk);
         #1;
      end
      memReady = 1'b0;
      @(negedge clk);
      chk("wrap_instret", instret, 32'd0);
      chk("wrap_pc_count", pc_count, 32'd1);
      chk("wrap_back_fetch", {31'd0, memRead}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
